// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N byte-stream requesters.
// Define UART_TX_ARB_LOCK_EN to keep ownership until a requester's last byte of a message.
module uart_tx_arbiter #(
  parameter int N        = 4,
  parameter int DATA     = 8,
  parameter int TIMEOUT  = 1024,
  parameter int CNT_BITS = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic [N-1:0]          i_req,
  input  logic [N*DATA-1:0]     i_req_data,
  input  logic [N-1:0]          i_req_last,
  output logic [N-1:0]          o_req_ack,
  output logic [DATA-1:0]       o_tx_data,
  output logic                  o_tx_ready,
  input  logic                  i_tx_next,
  output logic [N-1:0]          o_grant,
  output logic                  o_err,
  output logic [CNT_BITS-1:0]   o_byte_count
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {ARB, WAIT_NEXT, PRESENT} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   g_idx;
  logic [TW-1:0]   tmo_cnt;
  logic [PW-1:0]   pick;
  logic [DATA-1:0] req_bytes [N];

  // First requester at or after start, wrapping from N-1 back to 0.
  function automatic logic [PW-1:0] rr_pick(input logic [N-1:0] req,
                                            input logic [PW-1:0] start);
    logic [PW-1:0] sel;
    logic [PW:0]   k;
    logic          found;
    sel   = start;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = {1'b0, start} + (PW+1)'(i);
      if (k >= (PW+1)'(N)) k = k - (PW+1)'(N);
      if (!found && req[k[PW-1:0]]) begin
        sel   = k[PW-1:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] idx);
    return (idx == PW'(N-1)) ? '0 : idx + 1'b1;
  endfunction

  function automatic logic [N-1:0] to_onehot(input logic [PW-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  always_comb begin
    for (int k = 0; k < N; k++) req_bytes[k] = i_req_data[k*DATA +: DATA];
  end

  always_comb begin
    pick = rr_pick(i_req, ptr);
  end

`ifdef UART_TX_ARB_LOCK_EN
  // Last-of-message flag captured with the byte so a requester changing it later has no effect.
  logic last_q;
`else
  logic unused_last;
  assign unused_last = ^i_req_last;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ARB;
      ptr          <= '0;
      g_idx        <= '0;
      tmo_cnt      <= '0;
      o_req_ack    <= '0;
      o_tx_data    <= '0;
      o_tx_ready   <= 1'b0;
      o_grant      <= '0;
      o_err        <= 1'b0;
      o_byte_count <= '0;
`ifdef UART_TX_ARB_LOCK_EN
      last_q       <= 1'b0;
`endif
    end else begin
      o_req_ack <= '0;
      o_err     <= 1'b0;
      if (i_en) begin
        unique case (state)
          ARB: begin
            if (|i_req) begin
              g_idx     <= pick;
              o_grant   <= to_onehot(pick);
              o_tx_data <= req_bytes[pick];
`ifdef UART_TX_ARB_LOCK_EN
              last_q    <= i_req_last[pick];
`endif
              state     <= WAIT_NEXT;
            end else begin
              o_grant <= '0;
            end
          end
          WAIT_NEXT: begin
            if (i_tx_next) begin
              o_tx_ready <= 1'b1;
              tmo_cnt    <= '0;
              state      <= PRESENT;
            end
          end
          PRESENT: begin
            // o_next falling is the transmitter's latch; it outranks a timeout on the same edge.
            if (!i_tx_next) begin
              o_tx_ready   <= 1'b0;
              o_req_ack    <= o_grant;
              o_byte_count <= o_byte_count + CNT_BITS'(1);
`ifdef UART_TX_ARB_LOCK_EN
              ptr          <= last_q ? rr_next(g_idx) : g_idx;
`else
              ptr          <= rr_next(g_idx);
`endif
              state        <= ARB;
            end else if (tmo_cnt == TW'(TIMEOUT-1)) begin
              o_tx_ready <= 1'b0;
              o_err      <= 1'b1;
              ptr        <= rr_next(g_idx);
              state      <= ARB;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          default: state <= ARB;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a small uart_tx handshake model driving o_next.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N        = 4;
  localparam int DATA     = 8;
  localparam int TIMEOUT  = 8;
  localparam int CNT_BITS = 3;
  localparam int BUSY     = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                en;
  logic [N-1:0]        req;
  logic [N*DATA-1:0]   req_data;
  logic [N-1:0]        req_last;
  logic [N-1:0]        req_ack;
  logic [DATA-1:0]     tx_data;
  logic                tx_ready;
  logic                tx_next;
  logic [N-1:0]        grant;
  logic                err;
  logic [CNT_BITS-1:0] byte_count;

  uart_tx_arbiter #(.N(N), .DATA(DATA), .TIMEOUT(TIMEOUT), .CNT_BITS(CNT_BITS)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
    .i_req(req), .i_req_data(req_data), .i_req_last(req_last),
    .o_req_ack(req_ack), .o_tx_data(tx_data), .o_tx_ready(tx_ready),
    .i_tx_next(tx_next), .o_grant(grant), .o_err(err), .o_byte_count(byte_count)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: o_next high in IDLE, latches on i_ready, then busy for BUSY enabled cycles.
  logic stall;
  int   busy;
  int   rx_count;
  assign tx_next = stall | (busy == 0);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= 0;
    else if (en) begin
      if (busy != 0) busy <= busy - 1;
      else if (!stall && tx_ready) begin
        busy     <= BUSY;
        rx_count <= rx_count + 1;
      end
    end
  end

  // Requester byte FIFOs; each requester holds its head byte until acked.
  logic [DATA-1:0] rq_data [N][16];
  logic            rq_last [N][16];
  int              rq_head [N];
  int              rq_tail [N];

  task automatic enq(input int k, input logic [DATA-1:0] d, input logic l);
    rq_data[k][rq_tail[k]] = d;
    rq_last[k][rq_tail[k]] = l;
    rq_tail[k] = (rq_tail[k] + 1) % 16;
  endtask

  initial forever begin
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (req_ack[k] && rq_head[k] != rq_tail[k]) rq_head[k] = (rq_head[k] + 1) % 16;
      req[k]                   = (rq_head[k] != rq_tail[k]);
      req_data[k*DATA +: DATA] = rq_data[k][rq_head[k]];
      req_last[k]              = rq_last[k][rq_head[k]];
    end
  end

  bit en_mode;
  int en_ph;
  initial forever begin
    @(negedge clk);
    if (en_mode) begin
      en    = (en_ph == 0);
      en_ph = (en_ph + 1) % 4;
    end
  end

  typedef struct packed {
    logic                err;
    logic [N-1:0]        who;
    logic [DATA-1:0]     data;
    logic [CNT_BITS-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ack(input int k, input logic [DATA-1:0] d, input logic [CNT_BITS-1:0] c);
    exp_t e;
    e.err = 1'b0; e.who = '0; e.who[k] = 1'b1; e.data = d; e.cnt = c;
    sb.push_back(e);
  endtask

  task automatic expect_err(input int k, input logic [DATA-1:0] d, input logic [CNT_BITS-1:0] c);
    exp_t e;
    e.err = 1'b1; e.who = '0; e.who[k] = 1'b1; e.data = d; e.cnt = c;
    sb.push_back(e);
  endtask

  initial forever begin
    exp_t e;
    @(posedge clk); #1;
    if (rst_n) begin
      if (!en) begin
        check("ack_cleared_when_disabled", {28'd0, req_ack}, 32'd0);
        check("err_cleared_when_disabled", {31'd0, err}, 32'd0);
      end
      if (|req_ack || err) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: ack=%b err=%b with nothing expected", req_ack, err);
        end else begin
          e = sb.pop_front();
          check("ack_vector", {28'd0, req_ack}, e.err ? 32'd0 : {28'd0, e.who});
          check("err_pulse",  {31'd0, err}, {31'd0, e.err});
          check("grant",      {28'd0, grant}, {28'd0, e.who});
          check("tx_data",    {24'd0, tx_data}, {24'd0, e.data});
          check("byte_count", {29'd0, byte_count}, {29'd0, e.cnt});
          check("tx_ready_dropped", {31'd0, tx_ready}, 32'd0);
        end
      end
    end
  end

  task automatic drain(input int maxc);
    int c = 0;
    while (sb.size() != 0 && c < maxc) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding after %0d cycles", sb.size(), c);
      sb.delete();
    end
    repeat (8) @(negedge clk);
    check("idle_grant", {28'd0, grant}, 32'd0);
    check("idle_ready", {31'd0, tx_ready}, 32'd0);
  endtask

  task automatic wait_ready(input string name);
    int c = 0;
    while (c < 50) begin
      @(posedge clk); #2;
      c++;
      if (tx_ready) break;
    end
    checks++;
    if (!tx_ready) begin
      errors++;
      $display("FAIL %s: tx_ready got 0 expected 1 within 50 cycles", name);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rx0;
    int n;
    rst_n = 1'b0; en = 1'b1; stall = 1'b0; rx_count = 0;
    repeat (3) @(negedge clk);
    check("rst_tx_ready",   {31'd0, tx_ready}, 32'd0);
    check("rst_tx_data",    {24'd0, tx_data}, 32'd0);
    check("rst_grant",      {28'd0, grant}, 32'd0);
    check("rst_req_ack",    {28'd0, req_ack}, 32'd0);
    check("rst_err",        {31'd0, err}, 32'd0);
    check("rst_byte_count", {29'd0, byte_count}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte from requester 1.
    enq(1, 8'hA5, 1'b1);
    expect_ack(1, 8'hA5, 3'd1);
    drain(100);

    // Reset while presenting: the byte must never reach the transmitter.
    stall = 1'b1;
    enq(3, 8'h77, 1'b1);
    wait_ready("reset_test_present");
    rx0 = rx_count;
    rst_n = 1'b0;
    #1;
    check("midrst_tx_ready",   {31'd0, tx_ready}, 32'd0);
    check("midrst_tx_data",    {24'd0, tx_data}, 32'd0);
    check("midrst_grant",      {28'd0, grant}, 32'd0);
    check("midrst_byte_count", {29'd0, byte_count}, 32'd0);
    for (int k = 0; k < N; k++) rq_head[k] = rq_tail[k];
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_byte_not_sent", rx_count, rx0);
    check("midrst_idle_grant", {28'd0, grant}, 32'd0);

    // Fairness: all four requesting, first grant must be requester 0.
    enq(0, 8'h10, 1'b1); enq(0, 8'h14, 1'b1);
    enq(1, 8'h11, 1'b1); enq(2, 8'h12, 1'b1); enq(3, 8'h13, 1'b1);
    expect_ack(0, 8'h10, 3'd1);
    expect_ack(1, 8'h11, 3'd2);
    expect_ack(2, 8'h12, 3'd3);
    expect_ack(3, 8'h13, 3'd4);
    expect_ack(0, 8'h14, 3'd5);
    drain(200);

    // Enable gating: 1 cycle on, 3 off; same sequence, stretched.
    @(negedge clk);
    en_ph = 0; en_mode = 1'b1;
    enq(2, 8'h5A, 1'b1); enq(3, 8'hC3, 1'b1);
    expect_ack(2, 8'h5A, 3'd6);
    expect_ack(3, 8'hC3, 3'd7);
    drain(400);
    @(negedge clk);
    en_mode = 1'b0; en = 1'b1;

    // Byte counter wraps 7 -> 0.
    enq(0, 8'h01, 1'b1); enq(1, 8'h02, 1'b1);
    expect_ack(0, 8'h01, 3'd0);
    expect_ack(1, 8'h02, 3'd1);
    drain(200);

    // Timeout: o_next held high; requester 3 wins next.
    stall = 1'b1;
    enq(2, 8'hEE, 1'b1); enq(3, 8'h33, 1'b1);
    expect_err(2, 8'hEE, 3'd1);
    expect_ack(3, 8'h33, 3'd2);
    wait_ready("timeout_present");
    n = 0;
    while (n < 40) begin
      @(posedge clk); #2;
      n++;
      if (err) break;
    end
    check("timeout_cycles", n, 8);
    rq_head[2] = (rq_head[2] + 1) % 16;
    stall = 1'b0;
    drain(200);

    // Acceptance lands on the same edge the timeout expires: acceptance wins.
    stall = 1'b1;
    enq(0, 8'h3C, 1'b1);
    expect_ack(0, 8'h3C, 3'd3);
    wait_ready("simul_present");
    repeat (6) @(posedge clk);
    #2;
    stall = 1'b0;
    drain(200);

    // Message of three bytes from requester 2 while requester 3 also requests.
    enq(2, 8'hA0, 1'b0); enq(2, 8'hA1, 1'b0); enq(2, 8'hA2, 1'b1);
    enq(3, 8'hB0, 1'b1);
`ifdef UART_TX_ARB_LOCK_EN
    expect_ack(2, 8'hA0, 3'd4);
    expect_ack(2, 8'hA1, 3'd5);
    expect_ack(2, 8'hA2, 3'd6);
    expect_ack(3, 8'hB0, 3'd7);
`else
    expect_ack(2, 8'hA0, 3'd4);
    expect_ack(3, 8'hB0, 3'd5);
    expect_ack(2, 8'hA1, 3'd6);
    expect_ack(2, 8'hA2, 3'd7);
`endif
    drain(300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one `uart_tx` transmitter between `N` byte-stream requesters. It picks a requester and latches its byte, then drives the transmitter's `i_data`/`i_ready` pair. It watches the transmitter's `o_next` to detect acceptance and returns a one-cycle acknowledge to the winner. It sits between the CPU-side console/debug sources and the single `uart_tx` instance, and runs on that transmitter's clock.

## Interface
- `N`, 4: number of requesters (2..8).
- `DATA`, 8: byte width; must equal `uart_tx` `DATA`.
- `TIMEOUT`, 1024: enabled cycles allowed between presenting a byte and its acceptance.
- `CNT_BITS`, 16: width of the transmitted-byte counter.

Ports:
- `i_clk` in 1: clock; the same clock that drives `uart_tx`.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_en` in 1: advance enable, tied to the `uart_tx` `i_en`.
- `i_req` in N: per-requester byte-valid.
- `i_req_data` in N*DATA: requester k's byte is at `[k*DATA +: DATA]`.
- `i_req_last` in N: the byte is the last of a message (used only with the lock feature).
- `o_req_ack` out N: one-cycle pulse; requester k's byte was accepted.
- `o_tx_data` out DATA: connects to `uart_tx` `i_data`.
- `o_tx_ready` out 1: connects to `uart_tx` `i_ready`.
- `i_tx_next` in 1: connects from `uart_tx` `o_next`.
- `o_grant` out N: one-hot current owner; 0 when idle.
- `o_err` out 1: one-cycle pulse when an acceptance timeout occurs.
- `o_byte_count` out CNT_BITS: number of bytes accepted since reset; wraps.

## Operation
- **States:** ARB, WAIT_NEXT, PRESENT.
- **All transitions** are qualified by `i_en`. When `i_en`=0, state, counters and outputs hold, except that `o_req_ack` and `o_err` are cleared.
- **ARB:**
  - If `i_req`≠0, select the first set bit at or after `ptr`, wrapping from N-1 to 0.
  - Register the winner as one-hot `o_grant`, latch its byte into `o_tx_data`, and go to WAIT_NEXT.
  - If `i_req`=0, `o_grant`=0 and the state stays in ARB.
- **WAIT_NEXT:** when `i_tx_next`=1, set `o_tx_ready`=1, clear the timeout counter, and go to PRESENT.
- **PRESENT:** `o_tx_ready` and `o_tx_data` hold.
  - **Acceptance:** `i_tx_next`=0 means the transmitter has latched the byte. Then:
    - `o_tx_ready`←0;
    - `o_req_ack[g]`←1 for one cycle;
    - `o_byte_count`++;
    - `ptr`←(g+1) mod N;
    - go to ARB.
  - **Timeout:** if the timeout counter reaches TIMEOUT-1 without acceptance:
    - `o_tx_ready`←0 and `o_err`←1 for one cycle;
    - no ack is issued and the count does not change;
    - `ptr`←(g+1) mod N;
    - go to ARB.
- **Requester changes after latching:** if the requester drops `i_req` or changes its data after latching, the latched byte is still sent and still acked.
- **Requester handshake:** a requester holds `i_req` and its data until its ack. It may reassert on the cycle after the ack.
- **Byte counter:** `o_byte_count` wraps from 2^CNT_BITS-1 to 0.
- **Reset mid-transfer:** all state clears immediately. `o_tx_ready`=0, so a byte not yet latched is never sent.

## Timing
- **Reset values:**
  - `o_tx_ready`=0, `o_tx_data`=0, `o_grant`=0, `o_req_ack`=0, `o_err`=0, `o_byte_count`=0;
  - `ptr`=0, state ARB.
- **Minimum latency** from `i_req` rising to `o_tx_ready`=1 is 2 enabled cycles: ARB, then WAIT_NEXT with `i_tx_next`=1.
- **Ack timing:** the ack pulses in the cycle after the first enabled edge where `i_tx_next`=0 is sampled in PRESENT.
- **Back-to-back traffic:** the next byte waits in WAIT_NEXT until `uart_tx` returns to IDLE and raises `o_next`. No byte is presented while `o_next`=0.
- **Simultaneous acceptance and timeout:** in the same cycle, acceptance wins.

## Configuration
- **Macro:** `UART_TX_ARB_LOCK_EN` enables message lock.
- **Defined:**
  - After an acked byte with `i_req_last[g]`=0, `ptr` is left at g, so the same requester wins the next ARB if it still requests.
  - If it does not request, normal round-robin applies.
  - The pointer advances only on an acked byte with `i_req_last[g]`=1, or on a timeout.
- **Undefined:** `i_req_last` is ignored and the pointer advances after every byte.

## Test plan
- **Single byte:** N=4. `i_req`=4'b0010, data 8'hA5, `i_tx_next` model mirrors `uart_tx` → `o_tx_data`=8'hA5, `o_grant`=4'b0010, one `o_req_ack`=4'b0010 pulse, `o_byte_count`=1.
- **Fairness:** all four requesters hold requests, bytes 8'h10..8'h13 → grant order 0,1,2,3,0, with one ack per byte and none skipped.
- **Enable gating:** `i_en` toggles 1 cycle on, 3 cycles off → same output sequence as with `i_en` always on, stretched; no state advance while `i_en`=0.
- **Timeout:** TIMEOUT=8, `i_tx_next` held at 1 forever after presenting → `o_err` pulses after 8 enabled cycles in PRESENT, no ack, `o_tx_ready`=0, next grant goes to requester g+1.
- **Reset mid-PRESENT:** pull `i_rst_n` low → all outputs 0 immediately. After release, the first grant goes to requester 0.
- **Lock (macro defined):** requester 2 sends 3 bytes with `i_req_last`=0,0,1 while requester 3 also requests → grants 2,2,2, then 3.
